instr_fetch_port: RTL and testbench
===================================

# instr_fetch_port

Fixed-latency instruction-fetch adapter between the Ibex instruction port and the instruction (B) port of the dual-port simulation RAM. It decodes each fetch against a configurable base/mask window and grants every request in the same cycle. In-range fetches are forwarded to RAM; out-of-range fetches get an in-order error response, so the core takes a fetch fault instead of hanging. It also keeps fetch and error counters and a sticky first-error address for the compliance bench.

## Interface
Parameters:
- ReadLatency, 1, RAM read latency in cycles from mem_req_o to valid mem_rdata_i; legal range 1..4.
- CountWidth, 32, width of fetch_count_o and err_count_o.

Ports:
- clk_i  in  1  clock; all state is updated on posedge.
- rst_ni  in  1  reset, asynchronous, active-low.
- cfg_addr_base_i  in  32  base of the RAM window.
- cfg_addr_mask_i  in  32  mask of the RAM window. A fetch is in range when (instr_addr_i & mask) == base.
- instr_req_i  in  1  core fetch request.
- instr_addr_i  in  32  core fetch address.
- instr_gnt_o  out  1  grant.
- instr_rvalid_o  out  1  response valid.
- instr_rdata_o  out  32  fetched word.
- instr_err_o  out  1  fetch error, qualified by instr_rvalid_o.
- mem_req_o  out  1  RAM port B request.
- mem_addr_o  out  32  word-aligned RAM address.
- mem_rdata_i  in  32  RAM read data.
- err_clr_i  in  1  clears err_seen_o and err_addr_o.
- fetch_count_o  out  CountWidth  number of granted fetches.
- err_count_o  out  CountWidth  number of error responses.
- err_seen_o  out  1  sticky error flag.
- err_addr_o  out  32  address of the first error since the last clear.

## Operation
- Decode: hit = (instr_addr_i & cfg_addr_mask_i) == cfg_addr_base_i.
- Grant: instr_gnt_o = instr_req_i, combinational, every cycle. No backpressure. Outstanding requests are bounded by ReadLatency.
- mem_req_o = instr_req_i & hit.
- mem_addr_o = {instr_addr_i[31:2], 2'b00}. It is driven in every cycle; RAM ignores it when mem_req_o is low.
- Response pipe: a ReadLatency-deep shift register of {valid, err} entries.
  - Stage 0 loads {instr_req_i, instr_req_i & ~hit} on each clock edge.
  - The last stage drives instr_rvalid_o and instr_err_o.
  - Responses are always returned in request order.
- rdata:
  - instr_rdata_o = mem_rdata_i when the last-stage entry is valid and not err.
  - Otherwise instr_rdata_o = 32'h0.
- Counters:
  - fetch_count_o increments on each granted request.
  - err_count_o increments on each response with instr_err_o = 1.
  - Both saturate at all-ones and never wrap.
- Sticky error:
  - On an out-of-range grant while err_seen_o = 0, capture instr_addr_i into err_addr_o and set err_seen_o.
  - Later errors do not overwrite err_addr_o.
  - err_clr_i zeroes both outputs.
  - If err_clr_i and a new error grant occur in the same cycle, the new error is captured: err_seen_o = 1 and err_addr_o = the new address.
- Config change while fetches are in flight: the in-flight err tags are already decided and unchanged. Only new grants use the new window.

## Timing
- Grant latency is 0 cycles.
- Response latency is exactly ReadLatency cycles after the grant edge, for both RAM and error responses.
- Back-to-back requests every cycle produce back-to-back rvalid every cycle, with no bubbles.
- Reset values:
  - All pipe entries are invalid.
  - instr_rvalid_o = 0, instr_err_o = 0, instr_rdata_o = 0.
  - Both counters = 0, err_seen_o = 0, err_addr_o = 0.
  - mem_req_o follows instr_req_i; the core holds instr_req_i low in reset.
- Reset asserted mid-operation: in-flight responses are dropped immediately and asynchronously. No rvalid is produced after deassertion for requests granted before reset.
- Counter saturation: a fetch at fetch_count_o = all-ones leaves the count unchanged.

## Structure
- No shared package entries are required.
- ReadLatency bounds are checked by an elaboration-time assertion in the module.
- Natural sub-module: instr_fetch_resp_pipe, a parameterised valid/err shift register with asynchronous clear.
- Counters and the sticky-error logic stay in the top module.
- Instantiated in the compliance top, replacing the inline gnt/rvalid logic on the instruction path.

## Test plan
- Window base 0x0, mask 0xFFE00000, ReadLatency 1; single fetch at 0x80, RAM word 0x00000013 -> gnt in the same cycle, rvalid one cycle later, rdata 0x00000013, err 0, fetch_count 1.
- Ten back-to-back fetches 0x80..0xA4 with ReadLatency 2 -> ten consecutive rvalid cycles starting 2 cycles after the first grant, data in order, no gaps.
- Fetch at 0x00300000 (out of range) -> mem_req_o stays 0, rvalid with err 1 and rdata 0; err_seen 1, err_addr 0x00300000, err_count 1.
- Two errors, 0x00300000 then 0x00400004, then err_clr_i asserted together with a third error at 0x00500008 -> err_addr holds 0x00300000 until the clear; after the clear err_addr = 0x00500008 and err_seen = 1.
- Interleaved hit, miss, hit with ReadLatency 3 -> responses in order: {data, err 0}, {0, err 1}, {data, err 0}.
- Reset pulsed while two fetches are in flight -> no rvalid after reset release, all outputs 0; a later fetch at 0x80 completes normally.

Source files
------------

// File: rtl/instr_fetch_port_pkg.sv
// Shared types and helpers for the instruction-fetch adapter.
package instr_fetch_port_pkg;

    localparam int unsigned AddrWidth      = 32;
    localparam int unsigned DataWidth      = 32;
    localparam int unsigned MinReadLatency = 1;
    localparam int unsigned MaxReadLatency = 4;

    // One response-pipe entry: a granted fetch and whether it was out of range.
    typedef struct packed {
        logic valid;
        logic err;
    } resp_tag_t;

    // Window decode: an address belongs to RAM when its masked bits equal the base.
    function automatic logic addr_hit(input logic [AddrWidth-1:0] addr,
                                      input logic [AddrWidth-1:0] mask,
                                      input logic [AddrWidth-1:0] base);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/instr_fetch_resp_pipe.sv
// Fixed-depth valid/err shift register that tracks fetches in flight.
// Cleared asynchronously so in-flight responses vanish on reset.
module instr_fetch_resp_pipe
    import instr_fetch_port_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  resp_tag_t tag_i,
    output resp_tag_t tag_o
);

    resp_tag_t [Depth-1:0] pipe_q;
    resp_tag_t [Depth-1:0] pipe_d;

    // Shift every entry one stage towards the output, loading stage 0.
    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = tag_i;
        for (int i = 1; i < int'(Depth); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Pipe state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tag_o = pipe_q[Depth-1];

endmodule

// File: rtl/instr_fetch_port.sv
// Fixed-latency instruction-fetch adapter: grants every request at once,
// forwards in-window fetches to RAM and answers out-of-window fetches
// with an in-order error response. Also keeps fetch/error statistics.
module instr_fetch_port
    import instr_fetch_port_pkg::*;
#(
    parameter int unsigned ReadLatency = 1,
    parameter int unsigned CountWidth  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [AddrWidth-1:0]  cfg_addr_base_i,
    input  logic [AddrWidth-1:0]  cfg_addr_mask_i,
    input  logic                  instr_req_i,
    input  logic [AddrWidth-1:0]  instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [DataWidth-1:0]  instr_rdata_o,
    output logic                  instr_err_o,
    output logic                  mem_req_o,
    output logic [AddrWidth-1:0]  mem_addr_o,
    input  logic [DataWidth-1:0]  mem_rdata_i,
    input  logic                  err_clr_i,
    output logic [CountWidth-1:0] fetch_count_o,
    output logic [CountWidth-1:0] err_count_o,
    output logic                  err_seen_o,
    output logic [AddrWidth-1:0]  err_addr_o
);

    if ((ReadLatency < MinReadLatency) || (ReadLatency > MaxReadLatency)) begin : gen_lat_check
        $error("instr_fetch_port: ReadLatency must be in 1..4");
    end

    logic      hit;
    logic      miss_grant;
    resp_tag_t tag_in;
    resp_tag_t tag_out;

    logic [CountWidth-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CountWidth-1:0] err_cnt_q, err_cnt_d;
    logic                  err_seen_q, err_seen_d;
    logic [AddrWidth-1:0]  err_addr_q, err_addr_d;

    assign hit        = addr_hit(instr_addr_i, cfg_addr_mask_i, cfg_addr_base_i);
    assign miss_grant = instr_req_i & ~hit;

    // Request side: zero-latency grant, RAM request only for in-window fetches.
    always_comb begin
        instr_gnt_o = instr_req_i;
        mem_req_o   = instr_req_i & hit;
        mem_addr_o  = {instr_addr_i[AddrWidth-1:2], 2'b00};
        tag_in      = '{valid: instr_req_i, err: miss_grant};
    end

    instr_fetch_resp_pipe #(
        .Depth (ReadLatency)
    ) u_resp_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .tag_i  (tag_in),
        .tag_o  (tag_out)
    );

    // Response side: RAM data only passes through for valid, non-error entries.
    always_comb begin
        instr_rvalid_o = tag_out.valid;
        instr_err_o    = tag_out.valid & tag_out.err;
        instr_rdata_o  = (tag_out.valid && !tag_out.err) ? mem_rdata_i : '0;
    end

    // Saturating fetch and error counters.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (instr_req_i && (fetch_cnt_q != '1)) begin
            fetch_cnt_d = fetch_cnt_q + CountWidth'(1);
        end
        if (instr_err_o && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CountWidth'(1);
        end
    end

    // Sticky first-error capture; a new error in the clear cycle wins over the clear.
    always_comb begin
        err_seen_d = err_seen_q;
        err_addr_d = err_addr_q;
        if (err_clr_i) begin
            err_seen_d = 1'b0;
            err_addr_d = '0;
        end
        if (miss_grant && (!err_seen_q || err_clr_i)) begin
            err_seen_d = 1'b1;
            err_addr_d = instr_addr_i;
        end
    end

    // Statistics state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_cnt_q <= '0;
            err_cnt_q   <= '0;
            err_seen_q  <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_seen_q  <= err_seen_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign fetch_count_o = fetch_cnt_q;
    assign err_count_o   = err_cnt_q;
    assign err_seen_o    = err_seen_q;
    assign err_addr_o    = err_addr_q;

endmodule

// File: tb/tb_instr_fetch_port.sv
// Directed scoreboard bench for instr_fetch_port (ReadLatency 3, 4-bit counters).
module tb_instr_fetch_port;

    localparam int unsigned LAT = 3;
    localparam int unsigned CW  = 4;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic [31:0]   cfg_base, cfg_mask;
    logic          instr_req_i;
    logic [31:0]   instr_addr_i;
    logic          instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0]   instr_rdata_o;
    logic          mem_req_o;
    logic [31:0]   mem_addr_o;
    logic [31:0]   mem_rdata_i;
    logic          err_clr_i;
    logic [CW-1:0] fetch_count_o, err_count_o;
    logic          err_seen_o;
    logic [31:0]   err_addr_o;

    always #5 clk = ~clk;

    instr_fetch_port #(
        .ReadLatency (LAT),
        .CountWidth  (CW)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .cfg_addr_base_i (cfg_base),
        .cfg_addr_mask_i (cfg_mask),
        .instr_req_i     (instr_req_i),
        .instr_addr_i    (instr_addr_i),
        .instr_gnt_o     (instr_gnt_o),
        .instr_rvalid_o  (instr_rvalid_o),
        .instr_rdata_o   (instr_rdata_o),
        .instr_err_o     (instr_err_o),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_rdata_i     (mem_rdata_i),
        .err_clr_i       (err_clr_i),
        .fetch_count_o   (fetch_count_o),
        .err_count_o     (err_count_o),
        .err_seen_o      (err_seen_o),
        .err_addr_o      (err_addr_o)
    );

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } ram_t;

    exp_t        sb[$];
    ram_t        ram_q[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [CW-1:0] m_fetch, m_errc;
    logic        m_seen;
    logic [31:0] m_addr;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ram_word(input logic [31:0] addr);
        logic [31:0] a;
        a = {addr[31:2], 2'b00};
        if (a == 32'h80) return 32'h0000_0013;
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        ram_q.delete();
        m_fetch = '0;
        m_errc  = '0;
        m_seen  = 1'b0;
        m_addr  = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rvalid"}, 32'(instr_rvalid_o), 32'h0);
        chk({tag, "_err"}, 32'(instr_err_o), 32'h0);
        chk({tag, "_rdata"}, instr_rdata_o, 32'h0);
        chk({tag, "_fcnt"}, 32'(fetch_count_o), 32'h0);
        chk({tag, "_ecnt"}, 32'(err_count_o), 32'h0);
        chk({tag, "_seen"}, 32'(err_seen_o), 32'h0);
        chk({tag, "_eaddr"}, err_addr_o, 32'h0);
        chk({tag, "_memreq"}, 32'(mem_req_o), 32'h0);
    endtask

    // One clock cycle: drive, check combinational and registered outputs, update model.
    task automatic step(input logic req, input logic [31:0] addr, input logic clr);
        logic hit;
        exp_t e;
        instr_req_i  = req;
        instr_addr_i = addr;
        err_clr_i    = clr;
        mem_rdata_i  = 32'hDEAD_BEEF;
        if (ram_q.size() != 0 && ram_q[0].due == cyc) begin
            mem_rdata_i = ram_word(ram_q[0].addr);
            void'(ram_q.pop_front());
        end
        #1;
        hit = (addr & cfg_mask) == cfg_base;
        chk("gnt", 32'(instr_gnt_o), 32'(req));
        chk("mem_req", 32'(mem_req_o), 32'(req & hit));
        if (req) chk("mem_addr", mem_addr_o, {addr[31:2], 2'b00});
        chk("fetch_count", 32'(fetch_count_o), 32'(m_fetch));
        chk("err_count", 32'(err_count_o), 32'(m_errc));
        chk("err_seen", 32'(err_seen_o), 32'(m_seen));
        chk("err_addr", err_addr_o, m_addr);
        if (sb.size() != 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("rvalid", 32'(instr_rvalid_o), 32'h1);
            chk("rerr", 32'(instr_err_o), 32'(e.err));
            chk("rdata", instr_rdata_o, e.data);
            if (e.err && m_errc != '1) m_errc = m_errc + 1'b1;
        end else begin
            chk("rvalid_idle", 32'(instr_rvalid_o), 32'h0);
            chk("rerr_idle", 32'(instr_err_o), 32'h0);
            chk("rdata_idle", instr_rdata_o, 32'h0);
        end
        if (req) begin
            e.due  = cyc + int'(LAT);
            e.err  = ~hit;
            e.data = hit ? ram_word(addr) : 32'h0;
            sb.push_back(e);
            if (hit) ram_q.push_back('{due: cyc + int'(LAT), addr: addr});
            if (m_fetch != '1) m_fetch = m_fetch + 1'b1;
        end
        if (clr) begin
            m_seen = 1'b0;
            m_addr = '0;
        end
        if (req && !hit && !m_seen) begin
            m_seen = 1'b1;
            m_addr = addr;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        instr_req_i  = 1'b0;
        instr_addr_i = '0;
        err_clr_i    = 1'b0;
        mem_rdata_i  = 32'hDEAD_BEEF;
        cfg_base     = 32'h0;
        cfg_mask     = 32'hFFE0_0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_ni = 1'b1;

        // Single in-range fetch.
        step(1'b1, 32'h80, 1'b0);
        idle(LAT + 1);

        // Ten back-to-back fetches: rvalid must be continuous and in order.
        for (int i = 0; i < 10; i++) step(1'b1, 32'h80 + 32'(4 * i), 1'b0);
        idle(LAT + 1);

        // Out-of-range fetch.
        step(1'b1, 32'h0030_0000, 1'b0);
        idle(LAT + 1);

        // Further errors do not overwrite; clear coinciding with an error captures it.
        step(1'b1, 32'h0030_0000, 1'b0);
        step(1'b1, 32'h0040_0004, 1'b0);
        step(1'b1, 32'h0050_0008, 1'b1);
        idle(LAT + 1);
        step(1'b0, 32'h0, 1'b1);
        idle(1);

        // Interleaved hit / miss / hit (unaligned hit address); fetch counter saturates here.
        step(1'b1, 32'h0000_008E, 1'b0);
        step(1'b1, 32'h0060_0000, 1'b0);
        step(1'b1, 32'h0000_0100, 1'b0);
        idle(LAT + 1);
        step(1'b1, 32'h0000_0104, 1'b0);
        idle(LAT + 1);

        // Reset while two fetches are in flight.
        step(1'b1, 32'h80, 1'b0);
        step(1'b1, 32'h84, 1'b0);
        rst_ni      = 1'b0;
        instr_req_i = 1'b0;
        #1;
        model_reset();
        chk_all_zero("midreset");
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        idle(LAT + 1);
        step(1'b1, 32'h80, 1'b0);
        idle(LAT + 1);
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
